// File: rtl/audio_pkg.sv
// Shared definitions for the ADC audio conditioner: pipeline state encoding,
// the ADC midpoint helper and a generic signed saturation helper.
package audio_pkg;

    // Pipeline sequencing states; one result walks through them once per block.
    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_SCALE   = 2'd1,
        S_FILTER  = 2'd2,
        S_PRESENT = 2'd3
    } state_e;

    // Midpoint code of an unsigned offset-binary ADC of the given width.
    function automatic int adc_midpoint(input int adc_w);
        return 1 << (adc_w - 1);
    endfunction

    // Clamp a wide signed value into the range of a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/audio_dc_blocker.sv
// First-order DC estimator/remover. The running sum dc_acc integrates the
// unsaturated output, so dc_acc >>> DC_SHIFT converges on the input mean and
// a constant input decays towards zero with time constant 2^DC_SHIFT results.
module audio_dc_blocker
    import audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int DC_SHIFT        = 10
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              en_i,
    input  logic signed [AUDIO_BIT_WIDTH-1:0] x_i,
    output logic signed [AUDIO_BIT_WIDTH:0]   y_o
);
    localparam int DC_ACC_W = AUDIO_BIT_WIDTH + DC_SHIFT + 1;

    logic signed [DC_ACC_W-1:0]      dc_acc_q;
    logic signed [DC_ACC_W-1:0]      dc_acc_d;
    logic signed [DC_ACC_W-1:0]      dc_full;
    logic signed [AUDIO_BIT_WIDTH:0] dc_est;

    // Subtract the current DC estimate and form the next integrator value.
    always_comb begin
        dc_full  = dc_acc_q >>> DC_SHIFT;
        dc_est   = (AUDIO_BIT_WIDTH + 1)'(dc_full);
        y_o      = (AUDIO_BIT_WIDTH + 1)'(x_i) - dc_est;
        dc_acc_d = dc_acc_q + DC_ACC_W'(y_o);
    end

    // The integrator only advances once per result, on the filter strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dc_acc_q <= '0;
        end else if (en_i) begin
            dc_acc_q <= dc_acc_d;
        end
    end

endmodule

// File: rtl/audio_adc_conditioner.sv
// Raw ADC samples -> box-car decimation -> signed audio word, optionally
// DC-blocked (define AUDIO_ADC_DC_BLOCK_EN), presented on a valid/ready
// holding register with a saturating count of dropped results.
module audio_adc_conditioner
    import audio_pkg::*;
#(
    parameter int ADC_BIT_WIDTH   = 12,
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int DECIM_LOG2      = 2,
    parameter int DC_SHIFT        = 10
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADC_BIT_WIDTH-1:0]   sample_in,
    input  logic                       sample_valid,
    output logic [AUDIO_BIT_WIDTH-1:0] out_word,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 overrun_count
);
    localparam int ACC_W      = ADC_BIT_WIDTH + DECIM_LOG2;
    localparam int CNT_W      = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int GAIN_SHIFT = AUDIO_BIT_WIDTH - ADC_BIT_WIDTH;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [ADC_BIT_WIDTH-1:0] ADC_MID  = ADC_BIT_WIDTH'(adc_midpoint(ADC_BIT_WIDTH));

    // Reject parameter sets the datapath widths cannot represent.
    if (AUDIO_BIT_WIDTH < ADC_BIT_WIDTH || DECIM_LOG2 < 0 || DC_SHIFT < 1) begin : g_bad_params
        $error("audio_adc_conditioner: unsupported parameter combination");
    end

    state_e                            state_q;
    logic [ACC_W-1:0]                  acc_q;
    logic [ACC_W-1:0]                  acc_d;
    logic [ACC_W-1:0]                  acc_sum;
    logic [CNT_W-1:0]                  cnt_q;
    logic [CNT_W-1:0]                  cnt_d;
    logic                              blk_done;
    logic [ACC_W-1:0]                  blk_sum_q;
    logic [ADC_BIT_WIDTH-1:0]          avg_w;
    logic signed [ADC_BIT_WIDTH-1:0]   centred;
    logic signed [AUDIO_BIT_WIDTH-1:0] x_scaled;
    logic signed [AUDIO_BIT_WIDTH-1:0] x_q;
    logic signed [AUDIO_BIT_WIDTH:0]   y_full;
    logic signed [AUDIO_BIT_WIDTH-1:0] y_sat;
    logic signed [AUDIO_BIT_WIDTH-1:0] y_q;
    logic [AUDIO_BIT_WIDTH-1:0]        out_word_q;
    logic                              out_valid_q;
    logic [7:0]                        overrun_q;

    // Running block sum; the block-completing sample is folded into acc_sum
    // and the accumulator restarts in the same cycle so no sample is lost.
    always_comb begin
        acc_sum  = acc_q + ACC_W'(sample_in);
        blk_done = sample_valid && (cnt_q == CNT_LAST);
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (sample_valid) begin
            if (blk_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Accumulator state; an asynchronous reset discards any partial block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Floor average, then re-centre: subtracting the midpoint of an
    // offset-binary code is the same as flipping its MSB.
    always_comb begin
        avg_w    = ADC_BIT_WIDTH'(blk_sum_q >> DECIM_LOG2);
        centred  = signed'(avg_w ^ ADC_MID);
        x_scaled = AUDIO_BIT_WIDTH'(centred) <<< GAIN_SHIFT;
    end

`ifdef AUDIO_ADC_DC_BLOCK_EN
    logic filter_en;
    assign filter_en = (state_q == S_FILTER);

    audio_dc_blocker #(
        .AUDIO_BIT_WIDTH (AUDIO_BIT_WIDTH),
        .DC_SHIFT        (DC_SHIFT)
    ) u_dc_blocker (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (filter_en),
        .x_i     (x_q),
        .y_o     (y_full)
    );
`else
    assign y_full = (AUDIO_BIT_WIDTH + 1)'(x_q);
`endif

    assign y_sat = AUDIO_BIT_WIDTH'(sat_signed(64'(y_full), AUDIO_BIT_WIDTH));

    // Pipeline sequencer and output holding register with overrun tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_ACCUM;
            blk_sum_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= '0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_ACCUM: begin
                    if (blk_done) begin
                        blk_sum_q <= acc_sum;
                        state_q   <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    x_q     <= x_scaled;
                    state_q <= S_FILTER;
                end
                S_FILTER: begin
                    y_q     <= y_sat;
                    state_q <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_valid_q && !out_ready) begin
                        if (overrun_q != 8'hFF) begin
                            overrun_q <= overrun_q + 8'd1;
                        end
                    end else begin
                        out_word_q  <= y_q;
                        out_valid_q <= 1'b1;
                    end
                    state_q <= S_ACCUM;
                end
                default: state_q <= S_ACCUM;
            endcase
        end
    end

    assign out_word      = out_word_q;
    assign out_valid     = out_valid_q;
    assign overrun_count = overrun_q;

endmodule
